// File: rtl/lfsr_serial_gen.sv
// lfsr_serial_gen: parametrised LFSR PRBS source with a serial LSB-first dump.
// The register steps while Enable is high; a rising edge on OUT_Enable
// requests a dump, which streams the register out with Valid once Enable is low.
// Optional build macro: LFSR_GALOIS_EN selects a Galois step instead of Fibonacci.
module lfsr_serial_gen #(
    parameter int unsigned         LFSR_WD      = 8,
    parameter logic [LFSR_WD-1:0]  DEFAULT_POLY = LFSR_WD'(8'h1D)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [LFSR_WD-1:0] Seed,
    input  logic [LFSR_WD-1:0] Poly,
    input  logic               Load,
    input  logic               Enable,
    input  logic               OUT_Enable,
    output logic               OUT,
    output logic               Valid,
    output logic               Busy,
    output logic [LFSR_WD-1:0] LFSR_State
);

    localparam int unsigned CNT_WD = $clog2(LFSR_WD + 1);
    localparam logic [CNT_WD-1:0] LAST_CNT = CNT_WD'(LFSR_WD);
    localparam logic [LFSR_WD-1:0] ONE     = LFSR_WD'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SERIAL = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LFSR_WD-1:0] lfsr_q, lfsr_d;
    logic [LFSR_WD-1:0] poly_q, poly_d;
    logic [CNT_WD-1:0]  cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               oe_q;
    logic               out_q, out_d;
    logic               valid_q, valid_d;
    logic               busy_q;

    logic [LFSR_WD-1:0] step_c;
    logic [LFSR_WD-1:0] rot_c;
    logic [LFSR_WD-1:0] seed_c;
    logic               oe_rise_c;

    // One LFSR advance in the selected structure
`ifdef LFSR_GALOIS_EN
    always_comb begin
        step_c = (lfsr_q >> 1) ^ (lfsr_q[0] ? poly_q : '0);
    end
`else
    always_comb begin
        step_c = {^(lfsr_q & poly_q), lfsr_q[LFSR_WD-1:1]};
    end
`endif

    // Rotation used by the dump so the register is restored after LFSR_WD bits
    assign rot_c     = {lfsr_q[0], lfsr_q[LFSR_WD-1:1]};
    // All-zero seed would lock the register up, so substitute 1
    assign seed_c    = (Seed == '0) ? ONE : Seed;
    assign oe_rise_c = OUT_Enable & ~oe_q;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        poly_d  = poly_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        out_d   = 1'b0;
        valid_d = 1'b0;

        if (Load) begin
            lfsr_d  = seed_c;
            poly_d  = Poly;
            state_d = IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                SERIAL: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        out_d   = lfsr_q[0];
                        valid_d = 1'b1;
                        lfsr_d  = rot_c;
                        cnt_d   = cnt_q + CNT_WD'(1);
                    end
                end
                default: begin
                    if (oe_rise_c) begin
                        pend_d = 1'b1;
                    end
                    if (Enable) begin
                        lfsr_d  = step_c;
                        state_d = RUN;
                    end else if (pend_q) begin
                        state_d = SERIAL;
                        out_d   = lfsr_q[0];
                        valid_d = 1'b1;
                        lfsr_d  = rot_c;
                        cnt_d   = CNT_WD'(1);
                        pend_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            lfsr_q  <= seed_c;
            poly_q  <= DEFAULT_POLY;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            oe_q    <= 1'b0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            poly_q  <= poly_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            oe_q    <= OUT_Enable;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= (state_d == SERIAL);
        end
    end

    assign OUT        = out_q;
    assign Valid      = valid_q;
    assign Busy       = busy_q;
    assign LFSR_State = lfsr_q;

endmodule

// File: tb/tb_lfsr_serial_gen.sv
// Directed bench for lfsr_serial_gen (LFSR_WD=8, default poly 8'h1D).
module tb_lfsr_serial_gen;

    logic       Clock;
    logic       Reset;
    logic [7:0] Seed;
    logic [7:0] Poly;
    logic       Load;
    logic       Enable;
    logic       OUT_Enable;
    logic       OUT;
    logic       Valid;
    logic       Busy;
    logic [7:0] LFSR_State;

    int checks = 0;
    int errors = 0;

    lfsr_serial_gen #(.LFSR_WD(8)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Seed       (Seed),
        .Poly       (Poly),
        .Load       (Load),
        .Enable     (Enable),
        .OUT_Enable (OUT_Enable),
        .OUT        (OUT),
        .Valid      (Valid),
        .Busy       (Busy),
        .LFSR_State (LFSR_State)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Check 8 Valid bits LSB first, then the idle cycle after the dump
    task automatic dump_check(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("dump_valid%0d", i), 64'(Valid), 64'd1);
            chk($sformatf("dump_busy%0d", i), 64'(Busy), 64'd1);
            chk($sformatf("dump_out%0d", i), 64'(OUT), 64'(v[i]));
            tick();
        end
        chk("dump_end_valid", 64'(Valid), 64'd0);
        chk("dump_end_busy", 64'(Busy), 64'd0);
        chk("dump_end_out", 64'(OUT), 64'd0);
        chk("dump_end_state", 64'(LFSR_State), 64'(v));
    endtask

    logic [7:0] exp_seq [5];
    logic [7:0] exp_def [3];
    logic [7:0] bits4b;

    initial begin
        Reset = 1'b1; Seed = 8'h01; Poly = 8'h00; Load = 1'b0;
        Enable = 1'b0; OUT_Enable = 1'b0;
        tick();
        chk("rst_state", 64'(LFSR_State), 64'h01);
        chk("rst_valid", 64'(Valid), 64'd0);
        chk("rst_out", 64'(OUT), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        Reset = 1'b0;

`ifdef LFSR_GALOIS_EN
        Enable = 1'b1;
        tick();
        chk("gal_step1", 64'(LFSR_State), 64'h1D);
        tick();
        chk("gal_step2", 64'(LFSR_State), 64'h13);
        Enable = 1'b0;
        OUT_Enable = 1'b1;
        tick();
        chk("gal_pending_no_valid", 64'(Valid), 64'd0);
        OUT_Enable = 1'b0;
        tick();
        dump_check(8'h13);
`else
        // Fibonacci run from seed 1
        exp_seq[0] = 8'h80; exp_seq[1] = 8'h40; exp_seq[2] = 8'h20;
        exp_seq[3] = 8'h10; exp_seq[4] = 8'h88;
        Enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("run%0d", i), 64'(LFSR_State), 64'(exp_seq[i]));
            chk($sformatf("run_valid%0d", i), 64'(Valid), 64'd0);
        end
        Enable = 1'b0;

        // Dump of 8'h88; OUT_Enable stays high to confirm no re-trigger
        OUT_Enable = 1'b1;
        tick();
        chk("req_no_valid", 64'(Valid), 64'd0);
        tick();
        dump_check(8'h88);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("held_oe_valid%0d", i), 64'(Valid), 64'd0);
        end
        OUT_Enable = 1'b0;

        // Zero seed guard on Load
        Seed = 8'h00; Poly = 8'h1D; Load = 1'b1;
        tick();
        Load = 1'b0;
        chk("load_zero_seed", 64'(LFSR_State), 64'h01);
        Enable = 1'b1;
        tick();
        Enable = 1'b0;
        chk("load_step", 64'(LFSR_State), 64'h80);

        // Abort a dump with Load on the third Valid cycle, Enable ignored
        OUT_Enable = 1'b1;
        tick();
        OUT_Enable = 1'b0;
        tick();
        chk("abort_v1", 64'(Valid), 64'd1);
        tick();
        tick();
        chk("abort_v3", 64'(Valid), 64'd1);
        chk("abort_v3_busy", 64'(Busy), 64'd1);
        Seed = 8'h5A; Load = 1'b1; Enable = 1'b1;
        tick();
        Load = 1'b0; Enable = 1'b0;
        chk("abort_valid", 64'(Valid), 64'd0);
        chk("abort_out", 64'(OUT), 64'd0);
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_state", 64'(LFSR_State), 64'h5A);
        tick();
        chk("abort_hold", 64'(LFSR_State), 64'h5A);
        chk("abort_no_restart", 64'(Valid), 64'd0);

        // Request during Enable is deferred until Enable falls
        exp_def[0] = 8'h2D; exp_def[1] = 8'h96; exp_def[2] = 8'h4B;
        Enable = 1'b1; OUT_Enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            OUT_Enable = 1'b0;
            chk($sformatf("defer_state%0d", i), 64'(LFSR_State), 64'(exp_def[i]));
            chk($sformatf("defer_valid%0d", i), 64'(Valid), 64'd0);
        end
        Enable = 1'b0;
        tick();
        bits4b = 8'h4B;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("defer_dump_valid%0d", i), 64'(Valid), 64'd1);
            chk($sformatf("defer_dump_out%0d", i), 64'(OUT), 64'(bits4b[i]));
            if (i < 3) tick();
        end

        // Reset on the fourth Valid cycle, zero seed also guarded on reset
        Reset = 1'b1; Seed = 8'h00;
        tick();
        chk("midrst_valid", 64'(Valid), 64'd0);
        chk("midrst_out", 64'(OUT), 64'd0);
        chk("midrst_busy", 64'(Busy), 64'd0);
        chk("midrst_state", 64'(LFSR_State), 64'h01);
        Reset = 1'b0;
        tick();
        chk("midrst_no_pending", 64'(Valid), 64'd0);

        // Poly of zero shifts zeros in
        Seed = 8'h81; Poly = 8'h00; Load = 1'b1;
        tick();
        Load = 1'b0; Enable = 1'b1;
        tick();
        chk("poly0_step", 64'(LFSR_State), 64'h40);
        Enable = 1'b0;

        // Reset restores the default polynomial
        Reset = 1'b1; Seed = 8'h01;
        tick();
        Reset = 1'b0; Enable = 1'b1;
        tick();
        Enable = 1'b0;
        chk("rst_default_poly", 64'(LFSR_State), 64'h80);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
